bcd_serial_adder_ctrl: RTL and testbench

- Sequenced multi-digit BCD adder. It time-shares one single-digit BCD add/correct stage across NDIGITS digit positions, one digit per clock, LSD first, with the carry held in a register.
- Start/Busy/Done handshake toward the board-level top, which takes operands from SW and shows Sum on the HEX displays.
- Scales the one-digit combinational BCD adder to N digits without replicating the stage.

---
 rtl/bcd_serial_adder_ctrl_if.sv | 28 ++
 rtl/bcd_serial_adder_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_bcd_serial_adder_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/bcd_serial_adder_ctrl_if.sv
// Start/Busy/Done handshake and operand/result bus of the sequenced BCD adder.
// The master drives the request and operands; the slave (the adder) returns
// the result, carry-out and status flags.
interface bcd_serial_adder_ctrl_if #(
  parameter int unsigned NDIGITS = 4
);
  localparam int unsigned W = 4 * NDIGITS;

  logic         Start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic [W-1:0] Sum;
  logic         Cout;
  logic         Busy;
  logic         Done;
  logic         Err;

  modport master (
    output Start, A, B, Cin,
    input  Sum, Cout, Busy, Done, Err
  );

  modport slave (
    input  Start, A, B, Cin,
    output Sum, Cout, Busy, Done, Err
  );
endinterface

// File: rtl/bcd_serial_adder_ctrl.sv
// Sequenced multi-digit BCD adder: one shared single-digit add/correct stage
// is stepped across NDIGITS positions, LSD first, with the carry held in a
// register between digits.  IDLE -> LOAD -> ADD (NDIGITS cycles) -> DONE.
// Optional macro BCD_DIGIT_CHECK_EN: flags operand digits above 9 on Err.
module bcd_serial_adder_ctrl #(
  parameter int unsigned NDIGITS = 4,
  parameter int unsigned CW      = 3
) (
  input  logic                    Clock,
  input  logic                    Resetn,
  bcd_serial_adder_ctrl_if.slave  bus
);

  localparam int unsigned    W        = 4 * NDIGITS;
  localparam logic [CW-1:0]  LAST_IDX = CW'(NDIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [3:0]    a_dig_c;
  logic [3:0]    b_dig_c;
  logic [4:0]    s_c;
  logic [3:0]    dig_c;
  logic          dig_carry_c;

  // Pick the operand digits addressed by the digit index
  always_comb begin
    a_dig_c = '0;
    b_dig_c = '0;
    for (int unsigned k = 0; k < NDIGITS; k++) begin
      if (idx_q == CW'(k)) begin
        a_dig_c = a_q[4*k +: 4];
        b_dig_c = b_q[4*k +: 4];
      end
    end
  end

  // Shared single-digit BCD add with +6 decimal correction (max s is 31)
  always_comb begin
    s_c = 5'(a_dig_c) + 5'(b_dig_c) + 5'(carry_q);
    if (s_c > 5'd9) begin
      dig_c       = 4'(s_c + 5'd6);
      dig_carry_c = 1'b1;
    end else begin
      dig_c       = s_c[3:0];
      dig_carry_c = 1'b0;
    end
  end

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      IDLE: begin
        if (bus.Start) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        a_d     = bus.A;
        b_d     = bus.B;
        carry_d = bus.Cin;
        sum_d   = '0;
        cout_d  = 1'b0;
        idx_d   = '0;
        state_d = ADD;
      end
      ADD: begin
        for (int unsigned k = 0; k < NDIGITS; k++) begin
          if (idx_q == CW'(k)) begin
            sum_d[4*k +: 4] = dig_c;
          end
        end
        carry_d = dig_carry_c;
        idx_d   = idx_q + CW'(1);
        if (idx_q == LAST_IDX) begin
          cout_d  = dig_carry_c;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags are registered, so decode them from the upcoming state
    busy_d = (state_d == LOAD) || (state_d == ADD);
    done_d = (state_d == DONE);
  end

  // State, datapath and output registers
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.Sum  = sum_q;
  assign bus.Cout = cout_q;
  assign bus.Busy = busy_q;
  assign bus.Done = done_q;

`ifdef BCD_DIGIT_CHECK_EN
  logic err_q, err_d;
  logic bad_digit_c;

  // Detect any non-BCD digit on the operands being captured
  always_comb begin
    bad_digit_c = 1'b0;
    for (int unsigned k = 0; k < NDIGITS; k++) begin
      if ((bus.A[4*k +: 4] > 4'd9) || (bus.B[4*k +: 4] > 4'd9)) begin
        bad_digit_c = 1'b1;
      end
    end
  end

  // Err is re-evaluated at LOAD and otherwise held
  always_comb begin
    err_d = err_q;
    if (state_q == LOAD) begin
      err_d = bad_digit_c;
    end
  end

  // Error flag register
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.Err = err_q;
`else
  assign bus.Err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Self-checking bench for bcd_serial_adder_ctrl (NDIGITS=4): table of vectors
// with hand-derived BCD sums, a result scoreboard popped on Done, and
// hand-written sequences for back-to-back Start and reset mid-ADD.
module tb_bcd_serial_adder_ctrl;

  localparam int unsigned ND = 4;

  logic clk;
  logic rstn;

  bcd_serial_adder_ctrl_if #(.NDIGITS(ND)) bus();

  bcd_serial_adder_ctrl #(.NDIGITS(ND), .CW(3)) dut (
    .Clock  (clk),
    .Resetn (rstn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        bad;
  } vec_t;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_err(input logic bad);
`ifdef BCD_DIGIT_CHECK_EN
    return bad;
`else
    return 1'b0;
`endif
  endfunction

  // Scoreboard: every Done pops the oldest expected result
  always @(negedge clk) begin
    exp_t e;
    if (rstn === 1'b1 && bus.Done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected: Done with empty scoreboard at %0t", $time);
      end else begin
        e = sb.pop_front();
        chk("sb_sum",  32'(bus.Sum),  32'(e.sum));
        chk("sb_cout", 32'(bus.Cout), 32'(e.cout));
        chk("sb_err",  32'(bus.Err),  32'(e.err));
      end
    end
  end

  // Run one operation starting at a negedge (cycle 0); ends 8 cycles later
  task automatic run_op(input vec_t v);
    exp_t e;
    e.sum = v.sum; e.cout = v.cout; e.err = exp_err(v.bad);
    bus.A = v.a; bus.B = v.b; bus.Cin = v.cin; bus.Start = 1'b1;
    sb.push_back(e);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) bus.Start = 1'b0;
      if (c == 2) begin
        chk("err_after_load", 32'(bus.Err), 32'(exp_err(v.bad)));
        bus.A = ~v.a; bus.B = v.b ^ 16'h5555; bus.Cin = ~v.cin;
      end
      chk($sformatf("busy_c%0d", c), 32'(bus.Busy), 32'(c <= 5));
      chk($sformatf("done_c%0d", c), 32'(bus.Done), 32'(c == 6));
    end
    @(negedge clk);
    @(negedge clk);
    chk("sum_hold",  32'(bus.Sum),  32'(v.sum));
    chk("cout_hold", 32'(bus.Cout), 32'(v.cout));
  endtask

  vec_t vt[10];

  initial begin
    int seen;
    exp_t e;

    vt[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vt[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[2] = '{16'h0999, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0};
    vt[3] = '{16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[4] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vt[5] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0};
    vt[6] = '{16'h0458, 16'h0567, 1'b0, 16'h1025, 1'b0, 1'b0};
    vt[7] = '{16'h4567, 16'h5432, 1'b1, 16'h0000, 1'b1, 1'b0};
    vt[8] = '{16'h12A4, 16'h0001, 1'b0, 16'h1305, 1'b0, 1'b1};
    vt[9] = '{16'h000F, 16'h000F, 1'b0, 16'h0014, 1'b0, 1'b1};

    rstn = 1'b0; bus.Start = 1'b0; bus.A = '0; bus.B = '0; bus.Cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_sum",  32'(bus.Sum),  32'h0);
    chk("rst_cout", 32'(bus.Cout), 32'h0);
    chk("rst_busy", 32'(bus.Busy), 32'h0);
    chk("rst_done", 32'(bus.Done), 32'h0);
    chk("rst_err",  32'(bus.Err),  32'h0);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_op(vt[i]);

    // Start held high; operands change during ADD; next LOAD in cycle 8
    bus.A = 16'h1111; bus.B = 16'h2222; bus.Cin = 1'b0; bus.Start = 1'b1;
    e.sum = 16'h3333; e.cout = 1'b0; e.err = 1'b0;
    sb.push_back(e);
    seen = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 2) begin bus.A = 16'h9999; bus.B = 16'h9999; end
      if (c == 6) chk("b2b_done6", 32'(bus.Done), 32'h1);
      if (c == 7) begin
        chk("b2b_idle_busy", 32'(bus.Busy), 32'h0);
        bus.A = 16'h0005; bus.B = 16'h0005;
        e.sum = 16'h0010; e.cout = 1'b0; e.err = 1'b0;
        sb.push_back(e);
      end
      if (c == 8) begin
        chk("b2b_load_busy", 32'(bus.Busy), 32'h1);
        bus.Start = 1'b0;
      end
      if (c == 9) begin bus.A = 16'h8888; bus.B = 16'h7777; end
      if (c > 8 && bus.Done === 1'b1 && seen == 0) seen = c;
    end
    chk("b2b_done_cycle", 32'(seen), 32'd13);

    // Reset asserted during the second ADD cycle discards the partial sum
    bus.A = 16'h1234; bus.B = 16'h4321; bus.Cin = 1'b0; bus.Start = 1'b1;
    @(negedge clk); bus.Start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_partial", 32'(bus.Sum), 32'h0005);
    rstn = 1'b0;
    #1;
    chk("mid_rst_sum",  32'(bus.Sum),  32'h0);
    chk("mid_rst_cout", 32'(bus.Cout), 32'h0);
    chk("mid_rst_busy", 32'(bus.Busy), 32'h0);
    chk("mid_rst_done", 32'(bus.Done), 32'h0);
    chk("mid_rst_err",  32'(bus.Err),  32'h0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    run_op(vt[6]);

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
